// File: rtl/spi_slave_core.sv
// SPI slave oversampled in the clk domain: all four CPOL/CPHA modes, configurable
// word width and bit order, show-ahead TX/RX FIFOs and sticky error flags.
module spi_slave_core #(
  parameter int                DATA_W       = 8,
  parameter int                TX_DEPTH     = 4,
  parameter int                RX_DEPTH     = 4,
  parameter int                SYNC_STAGES  = 2,
  parameter bit                LSB_FIRST    = 1'b0,
  parameter logic [DATA_W-1:0] UNDERRUN_PAT = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_sck,
  input  logic                      spi_ssn,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [DATA_W-1:0]         tx_dat,
  input  logic                      tx_vld,
  output logic                      tx_rdy,
  output logic [DATA_W-1:0]         rx_dat,
  output logic                      rx_vld,
  input  logic                      rx_rdy,
  output logic                      start,
  output logic                      done,
  output logic                      busy,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      tx_underrun,
  output logic                      rx_overrun,
  input  logic                      clr_err
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int CW  = $clog2(DATA_W);
  localparam logic [TAW:0]  TX_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0]  RX_FULL = (RAW+1)'(RX_DEPTH);
  localparam logic [CW-1:0] LAST    = CW'(DATA_W-1);

  // Top bit of the sck/ssn chains is the previous synced sample, used for edge detect.
  logic [SYNC_STAGES:0]   sck_q, ssn_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic sck_s, sck_p, ssn_s, ssn_p, mosi_s;
  logic act, lead, trail, samp_e, shift_e, load;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= '0;
      ssn_q  <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-1:0], spi_sck};
      ssn_q  <= {ssn_q[SYNC_STAGES-1:0], spi_ssn};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign sck_p  = sck_q[SYNC_STAGES];
  assign ssn_s  = ssn_q[SYNC_STAGES-1];
  assign ssn_p  = ssn_q[SYNC_STAGES];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign busy        = ~ssn_s;
  assign spi_miso_oe = busy;
  assign start       = ssn_p & ~ssn_s;
  assign done        = ~ssn_p & ssn_s;

  // Edges count only once select has been low for two synced samples.
  assign act     = ~ssn_s & ~ssn_p;
  assign lead    = act & (sck_p == cpol) & (sck_s != cpol);
  assign trail   = act & (sck_p != cpol) & (sck_s == cpol);
  assign samp_e  = cpha ? trail : lead;
  assign shift_e = cpha ? lead : trail;

  // ---------------- receive ----------------
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic              rx_push_q, rx_push_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    rx_push_d = 1'b0;
    if (!busy) begin
      bit_cnt_d = '0;
    end else if (samp_e) begin
      rx_sr_d = LSB_FIRST ? {mosi_s, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], mosi_s};
      if (bit_cnt_q == LAST) begin
        bit_cnt_d = '0;
        rx_push_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      rx_push_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      rx_push_q <= rx_push_d;
    end
  end

  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RAW-1:0]    rx_wr_q, rx_rd_q;
  logic [RAW:0]      rx_cnt_q;
  logic              rx_pop, rx_full, rx_wr, ovr_set;

  assign rx_vld   = (rx_cnt_q != '0);
  assign rx_dat   = rx_mem[rx_rd_q];
  assign rx_level = rx_cnt_q;
  assign rx_pop   = rx_vld & rx_rdy;
  assign rx_full  = (rx_cnt_q == RX_FULL);
  assign rx_wr    = rx_push_q & (~rx_full | rx_pop);
  assign ovr_set  = rx_push_q & rx_full & ~rx_pop;

  // ---------------- transmit ----------------
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0]    tx_wr_q, tx_rd_q;
  logic [TAW:0]      tx_cnt_q;
  logic              tx_push, tx_pop, tx_empty, urun_set;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d, tx_word;
  logic              miso_q;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_rdy   = ~rst & (tx_cnt_q != TX_FULL);
  assign tx_level = tx_cnt_q;
  assign tx_push  = tx_vld & tx_rdy;
  // cpha=0 preloads on select fall and again on the shift edge that follows each word.
  assign load     = (~cpha & start) | (shift_e & (bit_cnt_q == '0));
  assign tx_pop   = load & ~tx_empty;
  assign urun_set = load & tx_empty;
  assign tx_word  = tx_empty ? UNDERRUN_PAT : tx_mem[tx_rd_q];

  always_comb begin
    tx_sr_d = tx_sr_q;
    if (load)         tx_sr_d = tx_word;
    else if (shift_e) tx_sr_d = LSB_FIRST ? (tx_sr_q >> 1) : (tx_sr_q << 1);
  end

  assign spi_miso = miso_q;

  always_ff @(posedge clk) begin
    if (rx_wr)   rx_mem[rx_wr_q] <= rx_sr_q;
    if (tx_push) tx_mem[tx_wr_q] <= tx_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_cnt_q    <= '0;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      tx_cnt_q    <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      if (rx_wr)   rx_wr_q <= rx_wr_q + RAW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + RAW'(1);
      rx_cnt_q <= rx_cnt_q + (RAW+1)'(rx_wr) - (RAW+1)'(rx_pop);
      if (tx_push) tx_wr_q <= tx_wr_q + TAW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + TAW'(1);
      tx_cnt_q <= tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
      tx_sr_q  <= tx_sr_d;
      if (load | shift_e) miso_q <= LSB_FIRST ? tx_sr_d[0] : tx_sr_d[DATA_W-1];
      tx_underrun <= urun_set | (tx_underrun & ~clr_err);
      rx_overrun  <= ovr_set  | (rx_overrun  & ~clr_err);
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Scoreboard bench: u0 is 8-bit MSB-first with underrun pattern 0x5A, u1 is 12-bit LSB-first.
module tb_spi_slave_core;
  localparam int HALF = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] sck = 2'b00, ssn = 2'b11, mosi = 2'b00, cpol = 2'b00, cpha = 2'b00;

  logic [7:0]  tx_dat0 = '0;
  logic        tx_vld0 = 1'b0, rx_rdy0 = 1'b1, clr0 = 1'b0;
  logic        miso0, oe0, tx_rdy0, rx_vld0, start0, done0, busy0, urun0, ovr0;
  logic [7:0]  rx_dat0;
  logic [2:0]  tx_lvl0, rx_lvl0;

  logic [11:0] tx_dat1 = '0;
  logic        tx_vld1 = 1'b0, rx_rdy1 = 1'b1, clr1 = 1'b0;
  logic        miso1, oe1, tx_rdy1, rx_vld1, start1, done1, busy1, urun1, ovr1;
  logic [11:0] rx_dat1;
  logic [2:0]  tx_lvl1, rx_lvl1;

  spi_slave_core #(.DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4), .SYNC_STAGES(2),
                   .LSB_FIRST(1'b0), .UNDERRUN_PAT(8'h5A)) u0 (
    .clk(clk), .rst(rst), .spi_sck(sck[0]), .spi_ssn(ssn[0]), .spi_mosi(mosi[0]),
    .spi_miso(miso0), .spi_miso_oe(oe0), .cpol(cpol[0]), .cpha(cpha[0]),
    .tx_dat(tx_dat0), .tx_vld(tx_vld0), .tx_rdy(tx_rdy0),
    .rx_dat(rx_dat0), .rx_vld(rx_vld0), .rx_rdy(rx_rdy0),
    .start(start0), .done(done0), .busy(busy0), .tx_level(tx_lvl0), .rx_level(rx_lvl0),
    .tx_underrun(urun0), .rx_overrun(ovr0), .clr_err(clr0));

  spi_slave_core #(.DATA_W(12), .TX_DEPTH(4), .RX_DEPTH(4), .SYNC_STAGES(2),
                   .LSB_FIRST(1'b1), .UNDERRUN_PAT(12'h000)) u1 (
    .clk(clk), .rst(rst), .spi_sck(sck[1]), .spi_ssn(ssn[1]), .spi_mosi(mosi[1]),
    .spi_miso(miso1), .spi_miso_oe(oe1), .cpol(cpol[1]), .cpha(cpha[1]),
    .tx_dat(tx_dat1), .tx_vld(tx_vld1), .tx_rdy(tx_rdy1),
    .rx_dat(rx_dat1), .rx_vld(rx_vld1), .rx_rdy(rx_rdy1),
    .start(start1), .done(done1), .busy(busy1), .tx_level(tx_lvl1), .rx_level(rx_lvl1),
    .tx_underrun(urun1), .rx_overrun(ovr1), .clr_err(clr1));

  int vecs = 0, miss = 0;
  int start_cnt0 = 0, done_cnt0 = 0;
  logic [31:0] mexp0[$], mexp1[$], rexp0[$], rexp1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] st0();
    return {17'h0, tx_rdy0, miso0, oe0, rx_vld0, start0, done0, busy0, urun0, ovr0,
            tx_lvl0, rx_lvl0};
  endfunction

  function automatic logic cur_miso(input int w);
    return (w == 0) ? miso0 : miso1;
  endfunction

  task automatic rx_pop(input int w, input logic [31:0] d);
    logic [31:0] e;
    if ((w == 0 && rexp0.size() == 0) || (w == 1 && rexp1.size() == 0)) begin
      vecs++; miss++;
      $display("FAIL rx%0d unexpected word: got %h, none expected", w, d);
    end else begin
      if (w == 0) e = rexp0.pop_front();
      else        e = rexp1.pop_front();
      chk($sformatf("rx%0d word", w), d, e);
    end
  endtask

  // Monitor: every RX pop is checked against the scoreboard.
  always @(negedge clk) begin
    if (start0) start_cnt0++;
    if (done0)  done_cnt0++;
    if (rx_vld0 && rx_rdy0) rx_pop(0, {24'h0, rx_dat0});
    if (rx_vld1 && rx_rdy1) rx_pop(1, {20'h0, rx_dat1});
  end

  task automatic push_tx(input int w, input logic [31:0] d);
    @(negedge clk);
    if (w == 0) begin chk("tx_rdy u0", {31'h0, tx_rdy0}, 1); tx_dat0 = d[7:0];  tx_vld0 = 1'b1; end
    else        begin chk("tx_rdy u1", {31'h0, tx_rdy1}, 1); tx_dat1 = d[11:0]; tx_vld1 = 1'b1; end
    @(posedge clk); #1;
    tx_vld0 = 1'b0;
    tx_vld1 = 1'b0;
  endtask

  task automatic sel(input int w);
    @(negedge clk);
    sck[w] = cpol[w];
    ssn[w] = 1'b0;
    #(HALF);
  endtask

  task automatic desel(input int w);
    #(HALF);
    ssn[w] = 1'b1;
    #(2*HALF);
  endtask

  // Master: drives nb bits of mo, captures MISO on the master sample edge.
  task automatic xfer(input int w, input logic [31:0] mo, input int nb, input bit chkm);
    logic [31:0] mi, e, msk;
    int b;
    mi  = '0;
    msk = (32'd1 << nb) - 32'd1;
    for (int i = 0; i < nb; i++) begin
      b = (w == 1) ? i : nb - 1 - i;
      if (!cpha[w]) begin
        mosi[w] = mo[b]; #(HALF);
        sck[w] = ~cpol[w]; mi[b] = cur_miso(w); #(HALF);
        sck[w] = cpol[w];
      end else begin
        sck[w] = ~cpol[w]; mosi[w] = mo[b]; #(HALF);
        sck[w] = cpol[w]; mi[b] = cur_miso(w); #(HALF);
      end
    end
    if (chkm) begin
      if ((w == 0 && mexp0.size() == 0) || (w == 1 && mexp1.size() == 0)) begin
        vecs++; miss++;
        $display("FAIL miso%0d unexpected word: got %h", w, mi & msk);
      end else begin
        if (w == 0) e = mexp0.pop_front();
        else        e = mexp1.pop_front();
        chk($sformatf("miso%0d word", w), mi & msk, e);
      end
    end
  endtask

  task automatic clr_pulse0();
    @(negedge clk); clr0 = 1'b1;
    @(negedge clk); clr0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n, sc, dc;
    logic [7:0] ovb [5];
    ovb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset state u0", st0(), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset u0", st0(), 32'h4000);

    // Mode 0, two words
    push_tx(0, 32'hA5); push_tx(0, 32'h3C);
    mexp0.push_back(32'hA5); mexp0.push_back(32'h3C);
    rexp0.push_back(32'h81); rexp0.push_back(32'h7E);
    sc = start_cnt0; dc = done_cnt0;
    sel(0); xfer(0, 32'h81, 8, 1); xfer(0, 32'h7E, 8, 1); desel(0);
    chk("start pulses", start_cnt0 - sc, 1);
    chk("done pulses", done_cnt0 - dc, 1);
    chk("tx_level end", {29'h0, tx_lvl0}, 0);
    chk("reload after last word underruns", {31'h0, urun0}, 1);
    clr_pulse0();
    chk("clr_err clears underrun", {31'h0, urun0}, 0);

    // Underrun with clr_err held across the load: set wins
    clr0 = 1'b1;
    @(negedge clk); sck[0] = cpol[0]; ssn[0] = 1'b0;
    n = 0;
    while (!start0 && n < 20) begin @(negedge clk); n++; end
    chk("start seen in budget", {31'h0, start0}, 1);
    @(posedge clk); #1 clr0 = 1'b0;
    @(negedge clk);
    chk("underrun set beats clear", {31'h0, urun0}, 1);
    mexp0.push_back(32'h5A); rexp0.push_back(32'h00);
    xfer(0, 32'h00, 8, 1); desel(0);
    chk("underrun sticky", {31'h0, urun0}, 1);
    clr_pulse0();
    chk("underrun cleared", {31'h0, urun0}, 0);

    // Overrun: 5 bytes into a depth-4 RX FIFO with no pops
    @(posedge clk); #1 rx_rdy0 = 1'b0;
    sel(0);
    for (int i = 0; i < 5; i++) begin
      mexp0.push_back(32'h5A);
      if (i < 4) rexp0.push_back({24'h0, ovb[i]});
      xfer(0, {24'h0, ovb[i]}, 8, 1);
    end
    desel(0);
    chk("rx_level full", {29'h0, rx_lvl0}, 4);
    chk("rx_overrun set", {31'h0, ovr0}, 1);
    @(posedge clk); #1 rx_rdy0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("rx_level drained", {29'h0, rx_lvl0}, 0);
    clr_pulse0();
    chk("rx_overrun cleared", {31'h0, ovr0}, 0);

    // Select raised after 3 bits, then a full byte
    @(posedge clk); #1 rx_rdy0 = 1'b0;
    dc = done_cnt0;
    sel(0); xfer(0, 32'h5, 3, 0); desel(0);
    mexp0.push_back(32'h5A); rexp0.push_back(32'hC3);
    sel(0); xfer(0, 32'hC3, 8, 1); desel(0);
    chk("partial discarded level", {29'h0, rx_lvl0}, 1);
    chk("done twice", done_cnt0 - dc, 2);
    @(posedge clk); #1 rx_rdy0 = 1'b1;
    repeat (4) @(negedge clk);

    // u1: all four modes, 12-bit LSB-first
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      cpol[1] = m[1]; cpha[1] = m[0]; sck[1] = m[1];
      repeat (6) @(negedge clk);
      push_tx(1, 32'h123);
      mexp1.push_back(32'h123); rexp1.push_back(32'hABC);
      sel(1); xfer(1, 32'hABC, 12, 1); desel(1);
    end

    // Reset in the middle of a transfer
    push_tx(0, 32'h96); push_tx(0, 32'h77);
    sel(0); xfer(0, 32'hF0, 4, 0);
    @(negedge clk); rst = 1'b1; ssn[0] = 1'b1; sck[0] = cpol[0];
    @(posedge clk);
    @(negedge clk);
    chk("mid-transfer reset state", st0(), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("after mid reset", st0(), 32'h4000);
    push_tx(0, 32'h69);
    mexp0.push_back(32'h69); rexp0.push_back(32'h96);
    sel(0); xfer(0, 32'h96, 8, 1); desel(0);

    repeat (20) @(negedge clk);
    chk("rx0 scoreboard empty", rexp0.size(), 0);
    chk("rx1 scoreboard empty", rexp1.size(), 0);
    chk("miso scoreboards empty", mexp0.size() + mexp1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
